mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 23, byte-address width (8 MB main memory).
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for mem_ack; 0 disables timeout; legal range 0..65535.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 r0_req  in  1  loader request, held until r0_gnt.
REQ-007 r0_we / r0_addr / r0_wdata  in  1 / ADDR_W / 8  loader write-enable, address, write data.
REQ-008 r1_req  in  1  CPU request (fetch/LOAD/STORE), held until r1_gnt.
REQ-009 r1_we / r1_addr / r1_wdata  in  1 / ADDR_W / 8  CPU write-enable, address, write data.
REQ-010 r0_gnt, r1_gnt  out  1 each  one-cycle grant pulse; request fields captured that edge.
REQ-011 r0_done, r1_done  out  1 each  one-cycle completion pulse to owning requester.
REQ-012 rdata  out  8  read data, valid while a done is high.
REQ-013 err  out  1  timeout flag, valid while a done is high.
REQ-014 mem_req  out  1  memory access strobe, held until mem_ack.
REQ-015 mem_we / mem_addr / mem_wdata  out  1 / ADDR_W / 8  captured access fields.
REQ-016 mem_ack  in  1  memory completion; mem_rdata  in  8  read data valid with mem_ack.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; all outputs registered.
REQ-019 IDLE: at an edge with any req high, select winner, capture its we/addr/wdata into mem_*, assert its gnt and mem_req, go ACCESS, clear timeout counter.
REQ-020 gnt is high exactly the one cycle after the granting edge; requester may drop req afterwards; fields changed after the grant are ignored.
REQ-021 ACCESS: mem_req and mem_* held stable; edge with mem_ack high -> mem_req=0, rdata=mem_rdata for reads / 0 for writes, err=0, go RESP.
REQ-022 ACCESS timeout: counter increments per ACCESS cycle without ack; when TIMEOUT!=0 and counter reaches TIMEOUT -> mem_req=0, rdata=0, err=1, go RESP.
REQ-023 mem_ack sampled only in ACCESS; ack in IDLE/RESP is ignored.
REQ-024 RESP: owner's done high for exactly that cycle; next edge -> IDLE; no grant issued from RESP.
REQ-025 Latency: req sampled at edge E -> gnt/mem_req in cycle E+1; ack sampled at edge A -> done in cycle A+1; minimum 3 cycles per transaction.
REQ-026 Default priority: fixed, r0 (loader) wins when both request in the same IDLE cycle.
REQ-027 Requests arriving in ACCESS/RESP wait; no request is dropped while req held.
REQ-028 rdata/err hold their last value outside done cycles.

Reset
REQ-029 rst at an edge: state=IDLE, all outputs 0, counter 0, last-grant=r1; has priority over every other event.
REQ-030 Reset mid-ACCESS drops the transaction: mem_req low next cycle, no done issued.

Configuration
REQ-031 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests the requester not granted last wins; last-grant updates on every grant; first tie after reset goes to r0.
REQ-032 Macro undefined: fixed priority per REQ-026; last-grant register not built.

Verification
REQ-033 r1 read addr 0x000010, mem_ack 2 cycles after mem_req with mem_rdata=0x5A -> r1_gnt one pulse, r1_done one pulse, rdata=0x5A, err=0.
REQ-034 r0 and r1 assert same cycle, both held -> r0 served first, r1 granted in cycle after r0's RESP; with round-robin, second tie goes to r1.
REQ-035 r0 write addr 0x7A11FF data 0xC3 -> mem_we=1, mem_addr=0x7A11FF, mem_wdata=0xC3 stable until ack; done with rdata=0.
REQ-036 TIMEOUT=4, mem_ack never asserted -> mem_req drops after 4 ACCESS cycles, done with err=1, rdata=0; TIMEOUT=0 -> waits indefinitely.
REQ-037 rst asserted in second ACCESS cycle -> next cycle all outputs 0, no done; new r1 request afterwards served normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory-port and status signals of mem_arbiter.
//
// Handshake rules for every signal in this bundle:
//   - A requester raises rN_req together with rN_we/rN_addr/rN_wdata. It keeps
//     them stable until it sees the one-cycle rN_gnt pulse. The fields are
//     captured on the edge that produces rN_gnt, so they may change afterwards.
//   - The arbiter raises mem_req with mem_we/mem_addr/mem_wdata. It holds all
//     of them stable until the first edge at which it samples mem_ack high.
//     mem_rdata is only meaningful in that same cycle.
//   - rN_done pulses for one cycle to the owning requester. rdata and err are
//     valid while a done is high and keep their value afterwards.
//
// modport slave  : the arbiter's view of the bundle.
// modport master : the surrounding environment (requesters plus memory).
interface mem_arbiter_if #(
  parameter int ADDR_W = 23
);
  // requester 0 (loader)
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [7:0]        r0_wdata;
  logic              r0_gnt;
  logic              r0_done;
  // requester 1 (CPU)
  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [7:0]        r1_wdata;
  logic              r1_gnt;
  logic              r1_done;
  // shared response
  logic [7:0]        rdata;
  logic              err;
  // memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  // status
  logic              busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_ack, mem_rdata,
    output r0_gnt, r0_done, r1_gnt, r1_done,
    output rdata, err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_ack, mem_rdata,
    input  r0_gnt, r0_done, r1_gnt, r1_done,
    input  rdata, err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single byte-wide memory port.
// Requester 0 is the loader and requester 1 is the CPU. One transaction runs at
// a time and always passes through IDLE -> ACCESS -> RESP. Every output is a
// register.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to resolve simultaneous
// requests in favour of the requester that was not granted last. When the macro
// is undefined, requester 0 always wins a tie and no last-grant state is built.
//
// TIMEOUT is the number of ACCESS cycles to wait for mem_ack before giving up
// with err=1. A value of 0 makes the arbiter wait forever. Legal range is
// 0..65535.
//
// o_dbg_state exposes the FSM state (0 IDLE, 1 ACCESS, 2 RESP).
module mem_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic [1:0]   o_dbg_state
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_ACCESS = 2'd1;
  localparam logic [1:0]  S_RESP   = 2'd2;

  // One extra bit so that the incremented count never wraps before the compare.
  localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT);
  localparam bit          TO_EN    = (TIMEOUT != 0);

  // FSM and transaction state
  logic [1:0]        r_state;
  logic [15:0]       r_cnt;       // ACCESS cycles spent without mem_ack
  logic              r_owner;     // 1: requester 1 owns the transaction

  // registered outputs
  logic              r_r0_gnt;
  logic              r_r1_gnt;
  logic              r_r0_done;
  logic              r_r1_done;
  logic [7:0]        r_rdata;
  logic              r_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_busy;

  // winner selection and timeout detection
  logic              w_any_req;
  logic              w_win_r1;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [7:0]        w_win_wdata;
  logic [16:0]       w_cnt_next;
  logic              w_timeout;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              r_last;      // 1: requester 1 received the most recent grant
`endif

  assign w_any_req = bus.r0_req | bus.r1_req;

  // Pick the winner among the currently raised requests.
  always_comb begin
    w_win_r1 = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie, the requester that was not granted last wins.
    if (bus.r0_req && bus.r1_req) begin
      w_win_r1 = ~r_last;
    end else begin
      w_win_r1 = ~bus.r0_req;
    end
`else
    // Fixed priority: the loader wins whenever it is requesting.
    w_win_r1 = ~bus.r0_req;
`endif
  end

  // Route the winner's request fields toward the capture registers.
  always_comb begin
    w_win_we    = bus.r0_we;
    w_win_addr  = bus.r0_addr;
    w_win_wdata = bus.r0_wdata;
    if (w_win_r1) begin
      w_win_we    = bus.r1_we;
      w_win_addr  = bus.r1_addr;
      w_win_wdata = bus.r1_wdata;
    end
  end

  // Detect the ACCESS cycle in which the wait budget runs out.
  always_comb begin
    w_cnt_next = {1'b0, r_cnt} + 17'd1;
    w_timeout  = TO_EN && (w_cnt_next == TO_LIMIT);
  end

  // Main FSM. This block owns every output register and the transaction state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_owner     <= 1'b0;
      r_r0_gnt    <= 1'b0;
      r_r1_gnt    <= 1'b0;
      r_r0_done   <= 1'b0;
      r_r1_done   <= 1'b0;
      r_rdata     <= 8'd0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      // Grant and done are single-cycle pulses unless a state below sets them.
      r_r0_gnt  <= 1'b0;
      r_r1_gnt  <= 1'b0;
      r_r0_done <= 1'b0;
      r_r1_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_win_r1;
            r_r0_gnt    <= ~w_win_r1;
            r_r1_gnt    <= w_win_r1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_win_we;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
            r_cnt       <= 16'd0;
            r_busy      <= 1'b1;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (bus.mem_ack) begin
            // Writes report zero so that rdata never carries stale bus data.
            r_mem_req <= 1'b0;
            r_rdata   <= r_mem_we ? 8'd0 : bus.mem_rdata;
            r_err     <= 1'b0;
            r_r0_done <= ~r_owner;
            r_r1_done <= r_owner;
            r_state   <= S_RESP;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_rdata   <= 8'd0;
            r_err     <= 1'b1;
            r_r0_done <= ~r_owner;
            r_r1_done <= r_owner;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= w_cnt_next[15:0];
          end
        end
        S_RESP: begin
          // The done pulse is visible during this state. No grant is issued
          // here; a waiting request is picked up in the following IDLE cycle.
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember which requester received the last grant. Reset points at
  // requester 1, so the first tie after reset goes to requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last <= w_win_r1;
    end
  end
`endif

  assign bus.r0_gnt    = r_r0_gnt;
  assign bus.r1_gnt    = r_r1_gnt;
  assign bus.r0_done   = r_r0_done;
  assign bus.r1_done   = r_r1_done;
  assign bus.rdata     = r_rdata;
  assign bus.err       = r_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// dut_a is built with TIMEOUT=0 and serves a modelled memory.
// dut_b is built with TIMEOUT=4 and is used for the timeout scenario.
module tb_mem_arbiter;
  localparam int         AW        = 23;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard entries: {r1_done, r0_done, err, rdata}
  logic [10:0] exp_q[$];
  logic [10:0] sb_exp;
  logic [10:0] sb_got;

  bit resp_en   = 1'b0;
  int ack_delay = 2;

  mem_arbiter_if #(.ADDR_W(AW)) ifa ();
  mem_arbiter_if #(.ADDR_W(AW)) ifb ();

  mem_arbiter #(.ADDR_W(AW), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .o_dbg_state(dbg_a)
  );
  mem_arbiter #(.ADDR_W(AW), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .o_dbg_state(dbg_b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached by 500000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory model ----------------
  function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h4A;
  endfunction

  function automatic void push_exp(input logic owner_r1, input logic we, input logic [AW-1:0] a);
    logic [7:0] d;
    d = we ? 8'h00 : mem_val(a);
    exp_q.push_back({owner_r1, ~owner_r1, 1'b0, d});
  endfunction

  // Answer dut_a's mem_req after ack_delay cycles whenever resp_en is set.
  initial begin
    ifa.mem_ack   = 1'b0;
    ifa.mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (resp_en && ifa.mem_req) begin
        repeat (ack_delay) @(posedge clk);
        #1;
        ifa.mem_ack   = 1'b1;
        ifa.mem_rdata = mem_val(ifa.mem_addr);
        @(posedge clk); #1;
        ifa.mem_ack   = 1'b0;
        ifa.mem_rdata = 8'($urandom_range(0, 255));
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (ifa.r0_done || ifa.r1_done) begin
      n_checks++;
      sb_got = {ifa.r1_done, ifa.r0_done, ifa.err, ifa.rdata};
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected_done: got {r1_done,r0_done,err,rdata}=%b, required no done", sb_got);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          n_errors++;
          $display("FAIL sb_done: got {r1_done,r0_done,err,rdata}=%b, required %b", sb_got, sb_exp);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    ifa.r0_req = 0; ifa.r0_we = 0; ifa.r0_addr = '0; ifa.r0_wdata = 0;
    ifa.r1_req = 0; ifa.r1_we = 0; ifa.r1_addr = '0; ifa.r1_wdata = 0;
    ifb.r0_req = 0; ifb.r0_we = 0; ifb.r0_addr = '0; ifb.r0_wdata = 0;
    ifb.r1_req = 0; ifb.r1_we = 0; ifb.r1_addr = '0; ifb.r1_wdata = 0;
    ifb.mem_ack = 0; ifb.mem_rdata = 0;
    repeat (3) tick();
    n_checks++;
    if ({ifa.r0_gnt, ifa.r1_gnt, ifa.r0_done, ifa.r1_done, ifa.err, ifa.mem_req, ifa.mem_we,
         ifa.busy, ifa.rdata, ifa.mem_addr, ifa.mem_wdata, dbg_a} !== '0) begin
      n_errors++;
      $display("FAIL reset_a: gnt=%b%b done=%b%b err=%b mem_req=%b we=%b busy=%b rdata=%h addr=%h wdata=%h st=%0d, required all 0",
               ifa.r0_gnt, ifa.r1_gnt, ifa.r0_done, ifa.r1_done, ifa.err, ifa.mem_req, ifa.mem_we,
               ifa.busy, ifa.rdata, ifa.mem_addr, ifa.mem_wdata, dbg_a);
    end
    n_checks++;
    if ({ifb.r0_gnt, ifb.r1_gnt, ifb.r0_done, ifb.r1_done, ifb.err, ifb.mem_req, ifb.busy,
         ifb.rdata, dbg_b} !== '0) begin
      n_errors++;
      $display("FAIL reset_b: gnt=%b%b done=%b%b err=%b mem_req=%b busy=%b rdata=%h st=%0d, required all 0",
               ifb.r0_gnt, ifb.r1_gnt, ifb.r0_done, ifb.r1_done, ifb.err, ifb.mem_req, ifb.busy, ifb.rdata, dbg_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_basic();
    logic [AW-1:0] a;
    a = 23'h000010;
    resp_en = 1'b1; ack_delay = 2;
    ifa.r1_we = 0; ifa.r1_addr = a; ifa.r1_wdata = 8'hEE; ifa.r1_req = 1;
    push_exp(1'b1, 1'b0, a);
    tick();
    n_checks++;
    if ({ifa.r1_gnt, ifa.r0_gnt, ifa.mem_req, ifa.mem_we, ifa.busy} !== 5'b10101 || ifa.mem_addr !== a) begin
      n_errors++;
      $display("FAIL read_grant: r1_gnt=%b r0_gnt=%b mem_req=%b we=%b busy=%b addr=%h, required 1 0 1 0 1 %h",
               ifa.r1_gnt, ifa.r0_gnt, ifa.mem_req, ifa.mem_we, ifa.busy, ifa.mem_addr, a);
    end
    ifa.r1_req = 0;
    tick();
    n_checks++;
    if (ifa.r1_gnt !== 1'b0 || ifa.mem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL read_gnt_pulse: r1_gnt=%b mem_req=%b, required 0 1", ifa.r1_gnt, ifa.mem_req);
    end
    tick(); tick();
    n_checks++;
    if ({ifa.r1_done, ifa.r0_done, ifa.err, ifa.mem_req} !== 4'b1000 || ifa.rdata !== 8'h5A) begin
      n_errors++;
      $display("FAIL read_done: r1_done=%b r0_done=%b err=%b mem_req=%b rdata=%h, required 1 0 0 0 5a",
               ifa.r1_done, ifa.r0_done, ifa.err, ifa.mem_req, ifa.rdata);
    end
    tick();
    n_checks++;
    if ({ifa.r1_done, ifa.busy, ifa.err} !== 3'b000 || ifa.rdata !== 8'h5A || dbg_a !== ST_IDLE) begin
      n_errors++;
      $display("FAIL read_hold: r1_done=%b busy=%b err=%b rdata=%h st=%0d, required 0 0 0 5a 0",
               ifa.r1_done, ifa.busy, ifa.err, ifa.rdata, dbg_a);
    end
  endtask

  task automatic test_write();
    logic [AW-1:0] a;
    a = 23'h7A11FF;
    resp_en = 1'b1; ack_delay = 3;
    ifa.r0_we = 1; ifa.r0_addr = a; ifa.r0_wdata = 8'hC3; ifa.r0_req = 1;
    push_exp(1'b0, 1'b1, a);
    tick();
    n_checks++;
    if (ifa.r0_gnt !== 1'b1 || ifa.r1_gnt !== 1'b0) begin
      n_errors++;
      $display("FAIL write_grant: r0_gnt=%b r1_gnt=%b, required 1 0", ifa.r0_gnt, ifa.r1_gnt);
    end
    // Fields changed after the grant must not reach the memory port.
    ifa.r0_req = 0; ifa.r0_we = 0; ifa.r0_addr = 23'h000001; ifa.r0_wdata = 8'h11;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({ifa.mem_req, ifa.mem_we} !== 2'b11 || ifa.mem_addr !== a || ifa.mem_wdata !== 8'hC3) begin
        n_errors++;
        $display("FAIL write_stable[%0d]: mem_req=%b we=%b addr=%h wdata=%h, required 1 1 %h c3",
                 i, ifa.mem_req, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, a);
      end
      tick();
    end
    tick();
    n_checks++;
    if ({ifa.r0_done, ifa.err, ifa.mem_req} !== 3'b100 || ifa.rdata !== 8'h00) begin
      n_errors++;
      $display("FAIL write_done: r0_done=%b err=%b mem_req=%b rdata=%h, required 1 0 0 00",
               ifa.r0_done, ifa.err, ifa.mem_req, ifa.rdata);
    end
    tick();
  endtask

  task automatic test_tie();
    bit   seen;
    logic e;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    e = 1'b1;
`else
    e = 1'b0;
`endif
    resp_en = 1'b1; ack_delay = 1;
    push_exp(1'b0, 1'b0, 23'h000100);
    if (e) begin
      push_exp(1'b1, 1'b0, 23'h000200);
      push_exp(1'b0, 1'b0, 23'h000300);
    end else begin
      push_exp(1'b0, 1'b0, 23'h000300);
      push_exp(1'b1, 1'b0, 23'h000200);
    end
    ifa.r0_we = 0; ifa.r0_addr = 23'h000100; ifa.r0_req = 1;
    ifa.r1_we = 0; ifa.r1_addr = 23'h000200; ifa.r1_req = 1;
    tick();
    n_checks++;
    if ({ifa.r0_gnt, ifa.r1_gnt} !== 2'b10 || ifa.mem_addr !== 23'h000100) begin
      n_errors++;
      $display("FAIL tie_first: r0_gnt=%b r1_gnt=%b addr=%h, required 1 0 000100", ifa.r0_gnt, ifa.r1_gnt, ifa.mem_addr);
    end
    ifa.r0_req = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (ifa.r0_done || ifa.r1_done) seen = 1;
    end
    n_checks++;
    if (!seen || ifa.r0_done !== 1'b1) begin
      n_errors++;
      $display("FAIL tie_first_done: seen=%b r0_done=%b, required 1 1", seen, ifa.r0_done);
    end
    // The loader asks again while r1 is still waiting: a second tie.
    ifa.r0_addr = 23'h000300; ifa.r0_req = 1;
    tick();
    n_checks++;
    if ({ifa.r0_gnt, ifa.r1_gnt, ifa.busy} !== 3'b000) begin
      n_errors++;
      $display("FAIL tie_idle_gap: r0_gnt=%b r1_gnt=%b busy=%b, required 0 0 0", ifa.r0_gnt, ifa.r1_gnt, ifa.busy);
    end
    tick();
    n_checks++;
    if ({ifa.r1_gnt, ifa.r0_gnt} !== {e, ~e} || ifa.mem_addr !== (e ? 23'h000200 : 23'h000300)) begin
      n_errors++;
      $display("FAIL tie_second: r1_gnt=%b r0_gnt=%b addr=%h, required %b %b %h",
               ifa.r1_gnt, ifa.r0_gnt, ifa.mem_addr, e, ~e, (e ? 23'h000200 : 23'h000300));
    end
    if (e) ifa.r1_req = 0; else ifa.r0_req = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (ifa.r0_gnt || ifa.r1_gnt) seen = 1;
    end
    n_checks++;
    if (!seen || {ifa.r1_gnt, ifa.r0_gnt} !== {~e, e}) begin
      n_errors++;
      $display("FAIL tie_third: seen=%b r1_gnt=%b r0_gnt=%b, required 1 %b %b", seen, ifa.r1_gnt, ifa.r0_gnt, ~e, e);
    end
    ifa.r0_req = 0; ifa.r1_req = 0;
    repeat (6) tick();
  endtask

  task automatic test_stray_ack();
    resp_en = 1'b0;
    ifa.mem_ack = 1'b1; ifa.mem_rdata = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({ifa.busy, ifa.mem_req, ifa.r0_done, ifa.r1_done} !== 4'b0000 || dbg_a !== ST_IDLE) begin
        n_errors++;
        $display("FAIL stray_ack[%0d]: busy=%b mem_req=%b done=%b%b st=%0d, required 0 0 00 0",
                 i, ifa.busy, ifa.mem_req, ifa.r0_done, ifa.r1_done, dbg_a);
      end
    end
    ifa.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_no_timeout();
    logic [AW-1:0] a;
    a = 23'h001234;
    resp_en = 1'b0;
    ifa.r1_we = 0; ifa.r1_addr = a; ifa.r1_req = 1;
    push_exp(1'b1, 1'b0, a);
    tick();
    ifa.r1_req = 0;
    repeat (300) tick();
    n_checks++;
    if ({ifa.mem_req, ifa.busy} !== 2'b11 || dbg_a !== ST_ACCESS) begin
      n_errors++;
      $display("FAIL no_timeout_wait: mem_req=%b busy=%b st=%0d, required 1 1 1", ifa.mem_req, ifa.busy, dbg_a);
    end
    ifa.mem_ack = 1'b1; ifa.mem_rdata = mem_val(a);
    tick();
    ifa.mem_ack = 1'b0;
    n_checks++;
    if ({ifa.r1_done, ifa.err} !== 2'b10 || ifa.rdata !== mem_val(a)) begin
      n_errors++;
      $display("FAIL no_timeout_done: r1_done=%b err=%b rdata=%h, required 1 0 %h", ifa.r1_done, ifa.err, ifa.rdata, mem_val(a));
    end
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    // A normal read first, so rdata and err hold non-timeout values.
    ifb.r0_we = 0; ifb.r0_addr = 23'h000055; ifb.r0_req = 1;
    tick();
    ifb.r0_req = 0;
    ifb.mem_ack = 1'b1; ifb.mem_rdata = 8'h77;
    tick();
    ifb.mem_ack = 1'b0;
    n_checks++;
    if ({ifb.r0_done, ifb.err} !== 2'b10 || ifb.rdata !== 8'h77) begin
      n_errors++;
      $display("FAIL timeout_pre: r0_done=%b err=%b rdata=%h, required 1 0 77", ifb.r0_done, ifb.err, ifb.rdata);
    end
    tick(); tick();
    ifb.r1_we = 0; ifb.r1_addr = 23'h000066; ifb.r1_req = 1;
    tick();
    ifb.r1_req = 0;
    cnt = (ifb.mem_req === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (ifb.mem_req !== 1'b1) break;
      tick();
      if (ifb.mem_req === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 4) begin
      n_errors++;
      $display("FAIL timeout_len: mem_req high for %0d cycles, required 4", cnt);
    end
    n_checks++;
    if ({ifb.r1_done, ifb.r0_done, ifb.err} !== 3'b101 || ifb.rdata !== 8'h00) begin
      n_errors++;
      $display("FAIL timeout_done: r1_done=%b r0_done=%b err=%b rdata=%h, required 1 0 1 00",
               ifb.r1_done, ifb.r0_done, ifb.err, ifb.rdata);
    end
    tick();
    n_checks++;
    if ({ifb.r1_done, ifb.busy, ifb.err} !== 3'b001 || ifb.rdata !== 8'h00) begin
      n_errors++;
      $display("FAIL timeout_hold: r1_done=%b busy=%b err=%b rdata=%h, required 0 0 1 00",
               ifb.r1_done, ifb.busy, ifb.err, ifb.rdata);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    resp_en = 1'b0;
    ifa.r1_we = 0; ifa.r1_addr = 23'h000040; ifa.r1_req = 1;
    tick();
    ifa.r1_req = 0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({ifa.r0_gnt, ifa.r1_gnt, ifa.r0_done, ifa.r1_done, ifa.err, ifa.mem_req, ifa.mem_we,
         ifa.busy, ifa.rdata, ifa.mem_addr, ifa.mem_wdata, dbg_a} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: gnt=%b%b done=%b%b err=%b mem_req=%b we=%b busy=%b rdata=%h addr=%h st=%0d, required all 0",
               ifa.r0_gnt, ifa.r1_gnt, ifa.r0_done, ifa.r1_done, ifa.err, ifa.mem_req, ifa.mem_we,
               ifa.busy, ifa.rdata, ifa.mem_addr, dbg_a);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifa.r0_done || ifa.r1_done || ifa.busy) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL reset_mid_quiet: activity=%b after reset, required 0", seen);
    end
    resp_en = 1'b1; ack_delay = 2;
    ifa.r1_we = 0; ifa.r1_addr = 23'h000080; ifa.r1_req = 1;
    push_exp(1'b1, 1'b0, 23'h000080);
    tick();
    n_checks++;
    if ({ifa.r1_gnt, ifa.mem_req} !== 2'b11 || ifa.mem_addr !== 23'h000080) begin
      n_errors++;
      $display("FAIL reset_mid_regrant: r1_gnt=%b mem_req=%b addr=%h, required 1 1 000080",
               ifa.r1_gnt, ifa.mem_req, ifa.mem_addr);
    end
    ifa.r1_req = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (ifa.r1_done) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL reset_mid_done: r1_done seen=%b, required 1", seen);
    end
    repeat (3) tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    test_reset();
    test_read_basic();
    test_write();
    test_tie();
    test_stray_ack();
    test_no_timeout();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: %0d expected completions never arrived, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
